// File: rtl/seq_subtractor_sliced.sv
// Multi-cycle subtractor: diff = in1 + ~in2 + 1 computed one SLICE-wide lookahead slice per clock,
// LSB slice first, with borrow/overflow/zero/neg flags registered alongside the final slice.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one slice of a_reg + b_reg + carry per edge, LSB slice first
// DONE  | result and flags held with out_valid high until out_ready

module seq_subtractor_sliced #(
    parameter int WIDTH = 32,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero,
    output logic             neg
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_overflow;
    logic             r_zero;
    logic             r_neg;

    int               w_base;
    logic             w_last;
    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE-1:0] w_sum;
    logic [SLICE:0]   w_c;
    logic             w_cout;
    logic [WIDTH-1:0] w_diff_next;

    assign w_base = int'(r_idx) * SLICE;
    assign w_last = (r_idx == IW'(N - 1));
    assign w_a_sl = r_a[w_base +: SLICE];
    assign w_b_sl = r_b[w_base +: SLICE];

    // Every carry is formed from the running group generate/propagate and the slice carry-in,
    // so no bit waits on the carry of the bit below it.
    always_comb begin : cla
        logic v_g;
        logic v_p;
        v_g    = 1'b0;
        v_p    = 1'b1;
        w_c    = '0;
        w_c[0] = r_carry;
        for (int i = 0; i < SLICE; i++) begin
            v_g        = (w_a_sl[i] & w_b_sl[i]) | ((w_a_sl[i] ^ w_b_sl[i]) & v_g);
            v_p        = (w_a_sl[i] ^ w_b_sl[i]) & v_p;
            w_c[i+1]   = v_g | (v_p & r_carry);
        end
        w_sum  = w_a_sl ^ w_b_sl ^ w_c[SLICE-1:0];
        w_cout = w_c[SLICE];
    end

    always_comb begin
        w_diff_next                    = r_diff;
        w_diff_next[w_base +: SLICE]   = w_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_a     <= in1;
                    r_b     <= ~in2;
                    r_carry <= 1'b1;
                    r_idx   <= '0;
                end
                S_RUN: begin
                    r_diff  <= w_diff_next;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IW'(1);
                    // r_b holds ~in2, so equal MSBs here mean the operands' signs differ.
                    if (w_last) begin
                        r_borrow   <= ~w_cout;
                        r_neg      <= w_diff_next[WIDTH-1];
                        r_zero     <= (w_diff_next == '0);
                        r_overflow <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                      (w_diff_next[WIDTH-1] != r_a[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign overflow  = r_overflow;
    assign zero      = r_zero;
    assign neg       = r_neg;

endmodule

// File: tb/tb_seq_subtractor_sliced.sv
// Drives a 32/16 and a 64/16 instance in lockstep and compares both against an arithmetic
// reference (signed/unsigned difference evaluated at extended precision).

module tb_seq_subtractor_sliced;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in1 = '0;
    logic [63:0] in2 = '0;

    logic        rdy0, vld0, bo0, ov0, z0, ng0;
    logic [31:0] diff0;
    logic        rdy1, vld1, bo1, ov1, z1, ng1;
    logic [63:0] diff1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_subtractor_sliced #(.WIDTH(32), .SLICE(16)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .in1(in1[31:0]), .in2(in2[31:0]), .out_valid(vld0), .out_ready(out_ready),
        .diff(diff0), .borrow(bo0), .overflow(ov0), .zero(z0), .neg(ng0)
    );

    seq_subtractor_sliced #(.WIDTH(64), .SLICE(16)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in1(in1), .in2(in2), .out_valid(vld1), .out_ready(out_ready),
        .diff(diff1), .borrow(bo1), .overflow(ov1), .zero(z1), .neg(ng1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                  output logic [63:0] d, output logic bo, output logic ov,
                                  output logic z, output logic ng);
        logic [63:0]        mask, a, b;
        logic signed [65:0] sa, sb, st, lim;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        a    = a_in & mask;
        b    = b_in & mask;
        d    = (a - b) & mask;
        bo   = (a < b);
        z    = (d == 64'd0);
        ng   = d[w-1];
        sa   = $signed({2'b00, a});
        sb   = $signed({2'b00, b});
        if (a[w-1]) sa = sa - (66'sd1 <<< w);
        if (b[w-1]) sb = sb - (66'sd1 <<< w);
        st   = sa - sb;
        lim  = 66'sd1 <<< (w - 1);
        ov   = (st >= lim) || (st < -lim);
    endfunction

    task automatic check_out(input string tag, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] d;
        logic        bo, ov, z, ng;
        model(32, a, b, d, bo, ov, z, ng);
        chk({tag, ".diff32"}, {32'b0, diff0}, d);
        chk({tag, ".flags32"}, {60'b0, bo0, ov0, z0, ng0}, {60'b0, bo, ov, z, ng});
        model(64, a, b, d, bo, ov, z, ng);
        chk({tag, ".diff64"}, diff1, d);
        chk({tag, ".flags64"}, {60'b0, bo1, ov1, z1, ng1}, {60'b0, bo, ov, z, ng});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".rdy_vld"}, {60'b0, rdy1, rdy0, vld1, vld0}, 64'b1100);
        chk({tag, ".diff32"}, {32'b0, diff0}, 64'd0);
        chk({tag, ".diff64"}, diff1, 64'd0);
        chk({tag, ".flags"}, {56'b0, bo0, ov0, z0, ng0, bo1, ov1, z1, ng1}, 64'd0);
    endtask

    task automatic op(input logic [63:0] a, input logic [63:0] b, input int hold, input string tag);
        int l0, l1;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        chk({tag, ".in_ready"}, {62'b0, rdy1, rdy0}, 64'd3);
        step();
        in_valid = 1'b0;
        in1      = {$urandom, $urandom};
        in2      = {$urandom, $urandom};
        l0 = 0;
        l1 = 0;
        for (int k = 1; k <= 12 && (l0 == 0 || l1 == 0); k++) begin
            step();
            if (vld0 && l0 == 0) l0 = k;
            if (vld1 && l1 == 0) l1 = k;
        end
        chk({tag, ".lat32"}, 64'(l0), 64'd2);
        chk({tag, ".lat64"}, 64'(l1), 64'd4);
        check_out(tag, a, b);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in1      = {$urandom, $urandom};
            in2      = {$urandom, $urandom};
            step();
            in_valid = 1'b0;
            chk({tag, ".hold_hs"}, {60'b0, vld1, vld0, rdy1, rdy0}, 64'b1100);
            check_out({tag, ".hold"}, a, b);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".release"}, {60'b0, vld1, vld0, rdy1, rdy0}, 64'b0011);
        if (hold > 0) begin
            repeat (3) begin
                step();
                chk({tag, ".dropped"}, {60'b0, vld1, vld0, rdy1, rdy0}, 64'b0011);
            end
        end
    endtask

    function automatic logic [63:0] rv(input int sel);
        logic [63:0] r;
        r = {$urandom, $urandom};
        case (sel)
            0: r = 64'd0;
            1: r = {64{1'b1}};
            2: r = 64'h0000_0000_8000_0000;
            3: r = 64'h8000_0000_0000_0000;
            4: r = r & 64'h0000_0000_0001_FFFF;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        #1;
        chk_reset_vals("reset_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_reset_vals("reset_after");

        op(64'd5, 64'd3, 0, "t1_5m3");
        op(64'd0, 64'd1, 0, "t2_0m1");
        op(64'h0000_0000_0001_0000, 64'd1, 0, "t3_slice_borrow");
        op(64'h0000_0000_8000_0000, 64'd1, 0, "t4_ovf_neg");
        op(64'h0000_0000_7FFF_FFFF, 64'h0000_0000_FFFF_FFFF, 0, "t4_ovf_pos");
        op(64'h8000_0000_0000_0000, 64'd1, 0, "t4_ovf64");
        op(64'h0001_0000_0000_0000, 64'd1, 0, "t3_borrow64");
        op(64'h0000_0000_1234_ABCD, 64'h0000_0000_1234_ABCD, 5, "t5_equal_hold");

        // reset while both instances are mid-RUN
        in1      = 64'h0123_4567_89AB_CDEF;
        in2      = 64'h0000_0000_0000_0001;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("t6_rst_run");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            step();
            chk("t6_no_result", {62'b0, vld1, vld0}, 64'd0);
        end

        // reset while both instances hold a result in DONE
        in1      = 64'd9;
        in2      = 64'd4;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("t6_done_reached", {62'b0, vld1, vld0}, 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("t6_rst_done");
        @(negedge clk);
        rst_n = 1'b1;
        op(64'd7, 64'd9, 0, "t6_after_rst");

        for (int i = 0; i < 4000; i++) begin
            logic [63:0] a, b;
            a = rv($urandom_range(0, 15));
            b = ($urandom_range(0, 15) == 0) ? a : rv($urandom_range(0, 15));
            op(a, b, 0, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
